cruise_speed_ctrl: RTL and testbench

- Cruise-control speed sequencer that sits both upstream and downstream of the 8-bit magnitude comparator Comp8.
- Drives comparator input A with the current vehicle speed register and input B with the latched cruise target.
- Consumes the comparator's L/EQ/G results to step speed toward the target while cruising.
- Handles driver inputs (throttle, brake, set, resume, cancel) through a small state machine.

---
 rtl/cruise_speed_ctrl_if.sv | 29 ++
 rtl/cruise_speed_ctrl.sv | 135 +++++++++++++
 tb/tb_cruise_speed_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cruise_speed_ctrl_if.sv
// Signal bundle between the cruise speed sequencer and its environment
// (driver controls, comparator results, speed/target/status outputs).
interface cruise_speed_ctrl_if #(
    parameter int W = 8
);
    logic         throttle;
    logic         brake;
    logic         set;
    logic         resume;
    logic         cancel;
    logic         L;
    logic         EQ;
    logic         G;
    logic [W-1:0] speed;
    logic [W-1:0] target;
    logic         cruise_active;
    logic [1:0]   state;
    logic         cmp_err;

    modport master (
        input  throttle, brake, set, resume, cancel, L, EQ, G,
        output speed, target, cruise_active, state, cmp_err
    );

    modport slave (
        output throttle, brake, set, resume, cancel, L, EQ, G,
        input  speed, target, cruise_active, state, cmp_err
    );
endinterface

// File: rtl/cruise_speed_ctrl.sv
// Cruise-control speed sequencer: steps the speed register toward a latched
// target using an external 8-bit magnitude comparator, under driver control.
module cruise_speed_ctrl #(
    parameter int           W          = 8,
    parameter logic [W-1:0] MIN_CRUISE = W'(45),
    parameter logic [W-1:0] MAX_SPEED  = W'(120),
    parameter int           BRAKE_STEP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    cruise_speed_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CRUISE   = 2'd1,
        OVERRIDE = 2'd2
    } CruiseState;

    localparam logic [W-1:0] BRAKE_W = W'(BRAKE_STEP);

    logic [W-1:0] r_speed;
    logic [W-1:0] r_target;
    logic         r_targetValid;
    CruiseState   r_state;
    logic         r_cmpErr;
    logic         r_setQ;
    logic         r_resumeQ;

    logic [W-1:0] w_nextSpeed;
    logic [W-1:0] w_nextTarget;
    logic         w_nextValid;
    CruiseState   w_nextState;
    logic         w_nextErr;

    logic         w_setRise;
    logic         w_resumeRise;
    logic         w_atMin;
    logic         w_cmpLegal;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic [W-1:0] w_brk;

    assign w_setRise    = bus.set & ~r_setQ;
    assign w_resumeRise = bus.resume & ~r_resumeQ;
    assign w_atMin      = (r_speed >= MIN_CRUISE);
    assign w_inc        = (r_speed >= MAX_SPEED) ? MAX_SPEED : r_speed + W'(1);
    assign w_dec        = (r_speed == '0) ? '0 : r_speed - W'(1);
    // Brake floors at zero rather than wrapping when speed < BRAKE_STEP.
    assign w_brk        = (r_speed >= BRAKE_W) ? r_speed - BRAKE_W : '0;
    assign w_cmpLegal   = ({bus.L, bus.EQ, bus.G} == 3'b100) ||
                          ({bus.L, bus.EQ, bus.G} == 3'b010) ||
                          ({bus.L, bus.EQ, bus.G} == 3'b001);

    always_comb begin
        w_nextSpeed  = r_speed;
        w_nextTarget = r_target;
        w_nextValid  = r_targetValid;
        w_nextState  = r_state;
        w_nextErr    = r_cmpErr;

        if (bus.brake) begin
            w_nextSpeed = w_brk;
            w_nextState = IDLE;
        end else if (bus.cancel) begin
            w_nextState = IDLE;
            w_nextSpeed = bus.throttle ? w_inc : w_dec;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.throttle) begin
                        w_nextSpeed = w_inc;
                    end else if (w_setRise && w_atMin) begin
                        w_nextTarget = r_speed;
                        w_nextValid  = 1'b1;
                        w_nextState  = CRUISE;
                    end else if (w_resumeRise && r_targetValid && w_atMin) begin
                        w_nextState = CRUISE;
                    end else begin
                        w_nextSpeed = w_dec;
                    end
                end
                CRUISE: begin
                    if (bus.throttle) begin
                        w_nextState = OVERRIDE;
                        w_nextSpeed = w_inc;
                    end else if (w_setRise) begin
                        w_nextTarget = r_speed;
                    end else if (w_cmpLegal) begin
                        if (bus.L) begin
                            w_nextSpeed = w_inc;
                        end else if (bus.G) begin
                            w_nextSpeed = w_dec;
                        end
                    end else begin
                        w_nextErr = 1'b1;
                    end
                end
                OVERRIDE: begin
                    if (bus.throttle) begin
                        w_nextSpeed = w_inc;
                    end else begin
                        w_nextState = CRUISE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_speed       <= '0;
            r_target      <= '0;
            r_targetValid <= 1'b0;
            r_state       <= IDLE;
            r_cmpErr      <= 1'b0;
            r_setQ        <= 1'b0;
            r_resumeQ     <= 1'b0;
        end else begin
            r_speed       <= w_nextSpeed;
            r_target      <= w_nextTarget;
            r_targetValid <= w_nextValid;
            r_state       <= w_nextState;
            r_cmpErr      <= w_nextErr;
            r_setQ        <= bus.set;
            r_resumeQ     <= bus.resume;
        end
    end

    assign bus.speed         = r_speed;
    assign bus.target        = r_target;
    assign bus.state         = r_state;
    assign bus.cruise_active = (r_state == CRUISE) | (r_state == OVERRIDE);
    assign bus.cmp_err       = r_cmpErr;
endmodule

// File: tb/tb_cruise_speed_ctrl.sv
// Bench for cruise_speed_ctrl: directed scenarios then randomized driver
// inputs, all checked against an arithmetic reference model of the rules.
module tb_cruise_speed_ctrl;
    localparam int W     = 8;
    localparam int MINC  = 45;
    localparam int MAXS  = 120;
    localparam int BSTEP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cruise_speed_ctrl_if #(.W(W)) bus ();

    cruise_speed_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Comparator model; can be overridden to inject illegal result patterns.
    logic forceCmp = 1'b0;
    logic fL = 1'b0, fEQ = 1'b0, fG = 1'b0;
    assign bus.L  = forceCmp ? fL  : (bus.speed <  bus.target);
    assign bus.EQ = forceCmp ? fEQ : (bus.speed == bus.target);
    assign bus.G  = forceCmp ? fG  : (bus.speed >  bus.target);

    int checks   = 0;
    int failures = 0;

    int mSpeed, mTarget, mState;
    bit mValid, mErr, mSetQ, mResQ;

    task automatic modelStep(input bit rn, th, br, st, rs, cn, l, eq, g);
        bit sr, rr;
        int inc, dec, brk;
        sr = st && !mSetQ;
        rr = rs && !mResQ;
        if (!rn) begin
            mSpeed = 0; mTarget = 0; mState = 0;
            mValid = 0; mErr = 0; mSetQ = 0; mResQ = 0;
            return;
        end
        mSetQ = st;
        mResQ = rs;
        inc = (mSpeed + 1 > MAXS) ? MAXS : mSpeed + 1;
        dec = (mSpeed - 1 < 0) ? 0 : mSpeed - 1;
        brk = (mSpeed - BSTEP < 0) ? 0 : mSpeed - BSTEP;
        if (br) begin
            mSpeed = brk; mState = 0;
        end else if (cn) begin
            mState = 0; mSpeed = th ? inc : dec;
        end else if (mState == 0) begin
            if (th) mSpeed = inc;
            else if (sr && mSpeed >= MINC) begin
                mTarget = mSpeed; mValid = 1; mState = 1;
            end else if (rr && mValid && mSpeed >= MINC) mState = 1;
            else mSpeed = dec;
        end else if (mState == 1) begin
            if (th) begin
                mState = 2; mSpeed = inc;
            end else if (sr) mTarget = mSpeed;
            else if (int'(l) + int'(eq) + int'(g) != 1) mErr = 1;
            else if (l) mSpeed = inc;
            else if (g) mSpeed = dec;
        end else begin
            if (th) mSpeed = inc;
            else mState = 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus.speed === W'(mSpeed)) else begin
            failures++;
            $error("FAIL %s speed observed=%0d expected=%0d", tag, bus.speed, mSpeed);
        end
        checks++;
        assert (bus.target === W'(mTarget)) else begin
            failures++;
            $error("FAIL %s target observed=%0d expected=%0d", tag, bus.target, mTarget);
        end
        checks++;
        assert (bus.state === 2'(mState)) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state, mState);
        end
        checks++;
        assert (bus.cruise_active === (mState != 0)) else begin
            failures++;
            $error("FAIL %s cruise_active observed=%0b expected=%0b", tag, bus.cruise_active, mState != 0);
        end
        checks++;
        assert (bus.cmp_err === mErr) else begin
            failures++;
            $error("FAIL %s cmp_err observed=%0b expected=%0b", tag, bus.cmp_err, mErr);
        end
    endtask

    task automatic expectConst(input string tag, input logic [7:0] obs, input int exp);
        checks++;
        assert (obs === 8'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive after the falling edge, sample at the next falling edge.
    task automatic applyStimulus(input bit rn, th, br, st, rs, cn);
        rst_n        = rn;
        bus.throttle = th;
        bus.brake    = br;
        bus.set      = st;
        bus.resume   = rs;
        bus.cancel   = cn;
        #1;
        modelStep(rn, th, br, st, rs, cn, bus.L, bus.EQ, bus.G);
        @(posedge clk);
        @(negedge clk);
        checkOutput("model");
    endtask

    initial begin
        bus.throttle = 1'b0; bus.brake = 1'b0; bus.set = 1'b0;
        bus.resume = 1'b0; bus.cancel = 1'b0;
        modelStep(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset with every input high, then release with brake still held
        forceCmp = 1; fL = 1; fEQ = 1; fG = 1;
        applyStimulus(0, 1, 1, 1, 1, 1);
        applyStimulus(0, 1, 1, 1, 1, 1);
        applyStimulus(1, 1, 1, 1, 1, 1);
        expectConst("rst_speed", bus.speed, 0);
        expectConst("rst_target", bus.target, 0);
        expectConst("rst_state", 8'(bus.state), 0);
        expectConst("rst_active", 8'(bus.cruise_active), 0);
        expectConst("rst_cmp_err", 8'(bus.cmp_err), 0);
        forceCmp = 0;

        for (int i = 0; i < 50; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        expectConst("accel_50", bus.speed, 50);
        applyStimulus(1, 0, 0, 1, 0, 0);
        expectConst("set_target", bus.target, 50);
        expectConst("set_state", 8'(bus.state), 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        expectConst("eq_hold", bus.speed, 50);

        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        expectConst("ovr_speed", bus.speed, 60);
        expectConst("ovr_state", 8'(bus.state), 2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        expectConst("ovr_release_state", 8'(bus.state), 1);
        expectConst("ovr_release_speed", bus.speed, 60);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        expectConst("g_decay", bus.speed, 50);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        expectConst("g_settled", bus.speed, 50);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
        expectConst("brake_speed", bus.speed, 44);
        expectConst("brake_state", 8'(bus.state), 0);
        expectConst("brake_target", bus.target, 50);
        applyStimulus(1, 0, 0, 0, 1, 0);
        expectConst("resume_low_ignored", 8'(bus.state), 0);
        for (int i = 0; i < 10 && mSpeed < MINC; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        expectConst("reach_45", bus.speed, 45);
        applyStimulus(1, 0, 0, 0, 1, 0);
        expectConst("resume_state", 8'(bus.state), 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        expectConst("l_climb", bus.speed, 50);

        for (int i = 0; i < 50; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        expectConst("accel_100", bus.speed, 100);
        for (int i = 0; i < 200; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        expectConst("saturate", bus.speed, 120);
        for (int i = 0; i < 100 && mSpeed > 2; i++) applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        expectConst("speed_1", bus.speed, 1);
        applyStimulus(1, 0, 1, 0, 0, 0);
        expectConst("brake_floor", bus.speed, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        expectConst("brake_floor_again", bus.speed, 0);

        for (int i = 0; i < 50; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        forceCmp = 1; fL = 1; fEQ = 0; fG = 1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        forceCmp = 0;
        expectConst("illegal_hold", bus.speed, 50);
        expectConst("illegal_err", 8'(bus.cmp_err), 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        expectConst("cancel_state", 8'(bus.state), 0);
        expectConst("err_sticky", 8'(bus.cmp_err), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        expectConst("err_reset", 8'(bus.cmp_err), 0);
        expectConst("mid_reset_target", bus.target, 0);

        for (int i = 0; i < 1500; i++) begin
            int thPct;
            thPct = ((i / 100) % 2 == 0) ? 80 : 35;
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 99) < thPct,
                          $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
